// File: rtl/dodge_obstacle_renderer.sv
// dodge_obstacle_renderer: pixel-stage dodge game core (FSM, player, falling obstacles, LFSR spawner, collision, score, RGB)
// Optional feature macro: DIFFICULTY_RAMP_EN (fall speed grows with score[7:4], capped at 15 px/frame)
module dodge_obstacle_renderer #(
    parameter int          NUM_OBS      = 4,
    parameter int          OBS_SIZE     = 16,
    parameter int          PLAYER_W     = 32,
    parameter int          PLAYER_H     = 16,
    parameter int          PLAYER_Y     = 448,
    parameter int          FALL_SPEED   = 4,
    parameter int          PLAYER_SPEED = 4,
    parameter int          SPAWN_FRAMES = 30,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  x_pixel,
    input  logic [9:0]  y_pixel,
    input  logic        display_enable,
    input  logic        h_sync,
    input  logic        v_sync,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_start,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        h_sync_out,
    output logic        v_sync_out,
    output logic        de_out,
    output logic [15:0] score,
    output logic        game_over
);
    localparam logic [9:0] P_MAX  = 10'(640 - PLAYER_W);
    localparam logic [9:0] O_MAX  = 10'(640 - OBS_SIZE);
    localparam logic [9:0] P_HOME = 10'((640 - PLAYER_W) / 2);
    localparam int         CW     = (SPAWN_FRAMES > 1) ? $clog2(SPAWN_FRAMES) : 1;

    typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

    state_t             state;
    logic [9:0]         player_x, player_nx;
    logic [NUM_OBS-1:0] obs_act, act_mv, free_oh;
    logic [9:0]         obs_x [NUM_OBS];
    logic [9:0]         obs_y [NUM_OBS];
    logic [9:0]         mv_y  [NUM_OBS];
    logic [15:0]        lfsr;
    logic [CW-1:0]      spawn_cnt;
    logic               hit, start_q;
    logic               frame_tick, start_rise, on_player, on_obs, spawn_now;
    logic [9:0]         fall, sum_x, spawn_x;
    logic [16:0]        score_sum;
    logic [15:0]        score_nx;
    logic [11:0]        rgb;

    assign frame_tick = x_pixel == 10'd0 && y_pixel == 10'd480;
    assign start_rise = btn_start && !start_q;
    assign on_player  = x_pixel >= player_x && x_pixel < player_x + 10'(PLAYER_W) &&
                        y_pixel >= 10'(PLAYER_Y) && y_pixel < 10'(PLAYER_Y + PLAYER_H);
    assign spawn_now  = spawn_cnt == CW'(SPAWN_FRAMES - 1);
    assign free_oh    = ~act_mv & (act_mv + NUM_OBS'(1));
    assign sum_x      = {1'b0, lfsr[8:0]} + {3'b000, lfsr[15:9]};
    assign spawn_x    = sum_x > O_MAX ? O_MAX : sum_x;
    assign score_nx   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
    assign player_nx  = (btn_left && !btn_right) ? (player_x < 10'(PLAYER_SPEED) ? 10'd0 : player_x - 10'(PLAYER_SPEED)) :
                        (btn_right && !btn_left) ? (player_x > P_MAX - 10'(PLAYER_SPEED) ? P_MAX : player_x + 10'(PLAYER_SPEED)) :
                        player_x;
    assign rgb        = !display_enable ? 12'h000 :
                        on_player ? (state == OVER ? 12'hF00 : 12'h0F0) :
                        on_obs ? 12'h840 : 12'h000;

`ifdef DIFFICULTY_RAMP_EN
    logic [4:0] ramp;
    assign ramp = 5'(FALL_SPEED) + {1'b0, score[7:4]};
    assign fall = ramp > 5'd15 ? 10'd15 : {5'd0, ramp};
`else
    assign fall = 10'(FALL_SPEED);
`endif

    // Does the current pixel fall inside any live obstacle square
    always_comb begin
        on_obs = 1'b0;
        for (int i = 0; i < NUM_OBS; i++)
            on_obs = on_obs | (obs_act[i] && x_pixel >= obs_x[i] && x_pixel < obs_x[i] + 10'(OBS_SIZE) &&
                               y_pixel >= obs_y[i] && y_pixel < obs_y[i] + 10'(OBS_SIZE));
    end

    // One frame of falling: new rows, survivors, and score after retirements
    always_comb begin
        act_mv    = '0;
        score_sum = {1'b0, score};
        for (int i = 0; i < NUM_OBS; i++) begin
            mv_y[i]   = obs_y[i] + fall;
            act_mv[i] = obs_act[i] && mv_y[i] < 10'd480;
            score_sum = score_sum + 17'(obs_act[i] && mv_y[i] >= 10'd480);
        end
    end

    // Game state: start edge, per-frame updates, sticky hit flag, free-running LFSR
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            player_x  <= P_HOME;
            obs_act   <= '0;
            score     <= '0;
            game_over <= 1'b0;
            lfsr      <= LFSR_SEED;
            spawn_cnt <= '0;
            hit       <= 1'b0;
            start_q   <= 1'b0;
            for (int i = 0; i < NUM_OBS; i++) begin
                obs_x[i] <= '0;
                obs_y[i] <= '0;
            end
        end else begin
            lfsr    <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
            start_q <= btn_start;
            if (state != PLAY) begin
                if (start_rise) begin
                    state     <= PLAY;
                    game_over <= 1'b0;
                    player_x  <= P_HOME;
                    obs_act   <= '0;
                    score     <= '0;
                    spawn_cnt <= '0;
                    hit       <= 1'b0;
                end
            end else if (frame_tick) begin
                hit <= 1'b0;
                if (hit) begin
                    state     <= OVER;
                    game_over <= 1'b1;
                end else begin
                    player_x  <= player_nx;
                    score     <= score_nx;
                    spawn_cnt <= spawn_now ? '0 : spawn_cnt + CW'(1);
                    obs_act   <= act_mv | (spawn_now ? free_oh : '0);
                    for (int i = 0; i < NUM_OBS; i++) begin
                        obs_y[i] <= (spawn_now && free_oh[i]) ? 10'd0 : mv_y[i];
                        obs_x[i] <= (spawn_now && free_oh[i]) ? spawn_x : obs_x[i];
                    end
                end
            end else if (display_enable && on_player && on_obs) begin
                hit <= 1'b1;
            end
        end
    end

    // Pixel output stage: colour and syncs share one register so they stay aligned
    always_ff @(posedge clk) begin
        if (reset) begin
            {red, green, blue} <= 12'h000;
            h_sync_out         <= 1'b1;
            v_sync_out         <= 1'b1;
            de_out             <= 1'b0;
        end else begin
            {red, green, blue} <= rgb;
            h_sync_out         <= h_sync;
            v_sync_out         <= v_sync;
            de_out             <= display_enable;
        end
    end
endmodule

// File: tb/tb_dodge_obstacle_renderer.sv
// tb_dodge_obstacle_renderer: vector table, directed game scenarios and randomized play against a behavioural model
module tb_dodge_obstacle_renderer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  x_pixel = '0, y_pixel = '0;
    logic        display_enable = 1'b0, h_sync = 1'b1, v_sync = 1'b1;
    logic        btn_left = 1'b0, btn_right = 1'b0, btn_start = 1'b0;
    logic [3:0]  red, green, blue;
    logic        h_sync_out, v_sync_out, de_out, game_over;
    logic [15:0] score;

    dodge_obstacle_renderer dut (
        .clk(clk), .reset(reset), .x_pixel(x_pixel), .y_pixel(y_pixel),
        .display_enable(display_enable), .h_sync(h_sync), .v_sync(v_sync),
        .btn_left(btn_left), .btn_right(btn_right), .btn_start(btn_start),
        .red(red), .green(green), .blue(blue),
        .h_sync_out(h_sync_out), .v_sync_out(v_sync_out), .de_out(de_out),
        .score(score), .game_over(game_over)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    logic [11:0] last_rgb;

    // model state: 0 idle, 1 play, 2 over
    int m_state, m_px, m_lfsr, m_cnt, m_score;
    bit m_hit, m_sq;
    int m_act[4], m_ox[4], m_oy[4];

    typedef struct {int x; int y; bit de; bit hs; bit vs; int rgb;} vec_t;
    vec_t tv[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit in_rect(int x, int y, int rx, int ry, int w, int h);
        return x >= rx && x < rx + w && y >= ry && y < ry + h;
    endfunction

    function automatic bit m_on_obs(int x, int y);
        for (int i = 0; i < 4; i++)
            if (m_act[i] != 0 && in_rect(x, y, m_ox[i], m_oy[i], 16, 16)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_colour(int x, int y, bit de);
        if (!de) return 0;
        if (in_rect(x, y, m_px, 448, 32, 16)) return m_state == 2 ? 'hF00 : 'h0F0;
        if (m_on_obs(x, y)) return 'h840;
        return 0;
    endfunction

    function automatic void m_reset();
        m_state = 0; m_px = 304; m_lfsr = 'hACE1; m_cnt = 0; m_score = 0; m_hit = 0; m_sq = 0;
        for (int i = 0; i < 4; i++) begin m_act[i] = 0; m_ox[i] = 0; m_oy[i] = 0; end
    endfunction

    function automatic void m_step(int x, int y, bit de, bit bl, bit br, bs);
        int nl, sp, lo, hi;
        bit tick, rise;
        tick = x == 0 && y == 480;
        rise = bs && !m_sq;
        nl = m_lfsr >> 1;
        if (m_lfsr % 2 == 1) nl = nl ^ 'hB400;
        if (m_state != 1) begin
            if (rise) begin
                m_state = 1; m_px = 304; m_score = 0; m_cnt = 0; m_hit = 0;
                for (int i = 0; i < 4; i++) m_act[i] = 0;
            end
        end else if (tick) begin
            if (m_hit) m_state = 2;
            else begin
                if (bl && !br) m_px = (m_px - 4 < 0) ? 0 : m_px - 4;
                if (br && !bl) m_px = (m_px + 4 > 608) ? 608 : m_px + 4;
`ifdef DIFFICULTY_RAMP_EN
                sp = 4 + (m_score / 16) % 16;
                if (sp > 15) sp = 15;
`else
                sp = 4;
`endif
                for (int i = 0; i < 4; i++)
                    if (m_act[i] != 0) begin
                        m_oy[i] += sp;
                        if (m_oy[i] >= 480) begin
                            m_act[i] = 0;
                            if (m_score < 65535) m_score++;
                        end
                    end
                m_cnt++;
                if (m_cnt == 30) begin
                    m_cnt = 0;
                    lo = m_lfsr % 512;
                    hi = (m_lfsr / 512) % 128;
                    for (int i = 0; i < 4; i++)
                        if (m_act[i] == 0) begin
                            m_act[i] = 1; m_oy[i] = 0; m_ox[i] = (lo + hi > 624) ? 624 : lo + hi;
                            break;
                        end
                end
            end
            m_hit = 0;
        end else if (de && in_rect(x, y, m_px, 448, 32, 16) && m_on_obs(x, y)) m_hit = 1;
        m_sq = bs;
        m_lfsr = nl;
    endfunction

    task automatic cyc(input int x, input int y, input bit de, input bit hs, input bit vs, input bit rst);
        int e_rgb;
        bit e_hs, e_vs, e_de;
        x_pixel = 10'(x); y_pixel = 10'(y); display_enable = de; h_sync = hs; v_sync = vs; reset = rst;
        if (rst) begin e_rgb = 0; e_hs = 1; e_vs = 1; e_de = 0; end
        else begin e_rgb = m_colour(x, y, de); e_hs = hs; e_vs = vs; e_de = de; end
        @(posedge clk); #1;
        if (rst) m_reset(); else m_step(x, y, de, btn_left, btn_right, btn_start);
        last_rgb = {red, green, blue};
        chk("rgb", {20'd0, last_rgb}, e_rgb);
        chk("sync_de", {29'd0, h_sync_out, v_sync_out, de_out}, {29'd0, e_hs, e_vs, e_de});
        chk("score", {16'd0, score}, m_score);
        chk("game_over", {31'd0, game_over}, {31'd0, m_state == 2});
    endtask

    task automatic px(input int x, input int y);
        cyc(x, y, x < 640 && y < 480, 1'($urandom), 1'($urandom), 1'b0);
    endtask

    task automatic pconst(input string name, input int x, input int y, input int exp);
        px(x, y);
        chk(name, {20'd0, last_rgb}, exp);
    endtask

    function automatic int edge_off(int a, int w);
        return a == 0 ? -1 : a == 1 ? 0 : a == 2 ? w - 1 : w;
    endfunction

    // one compressed frame: edge probes of player and live obstacles, random pixels, then frame_tick
    task automatic frame(input int nrand);
        int qx[$], qy[$];
        int rx, ry, w, h, x, y;
        for (int b = 0; b <= 4; b++) begin
            if (b < 4 && m_act[b] == 0) continue;
            rx = b < 4 ? m_ox[b] : m_px; ry = b < 4 ? m_oy[b] : 448;
            w = b < 4 ? 16 : 32; h = 16;
            for (int a = 0; a < 4; a++)
                for (int c = 0; c < 4; c++) begin
                    x = rx + edge_off(a, w); y = ry + edge_off(c, h);
                    if (x >= 0 && x < 640 && y >= 0 && y < 480) begin qx.push_back(x); qy.push_back(y); end
                end
        end
        for (int k = 0; k < nrand; k++) begin
            qx.push_back(int'($urandom_range(0, 639))); qy.push_back(int'($urandom_range(0, 479)));
        end
        foreach (qx[k]) px(qx[k], qy[k]);
        cyc(0, 480, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        btn_left = 0; btn_right = 0; btn_start = 0;
        repeat (2) cyc(0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic start_pulse();
        btn_start = 1; px(100, 100); btn_start = 0;
    endtask

    initial begin
        int tgt, px0;
        tv[0]  = '{304, 448, 1, 0, 1, 'h0F0};
        tv[1]  = '{335, 463, 1, 1, 0, 'h0F0};
        tv[2]  = '{303, 448, 1, 1, 1, 0};
        tv[3]  = '{336, 448, 1, 0, 0, 0};
        tv[4]  = '{304, 447, 1, 1, 1, 0};
        tv[5]  = '{304, 464, 1, 0, 1, 0};
        tv[6]  = '{320, 455, 1, 1, 0, 'h0F0};
        tv[7]  = '{320, 455, 0, 1, 1, 0};
        tv[8]  = '{0, 0, 1, 1, 1, 0};
        tv[9]  = '{639, 479, 1, 0, 0, 0};
        tv[10] = '{320, 100, 1, 1, 1, 0};
        tv[11] = '{700, 500, 0, 0, 0, 0};
        m_reset();
        do_reset();
        chk("reset_rgb", {20'd0, red, green, blue}, 0);
        chk("reset_sync", {29'd0, h_sync_out, v_sync_out, de_out}, 3'b110);
        chk("reset_score", {16'd0, score}, 0);
        chk("reset_over", {31'd0, game_over}, 0);
        for (int i = 0; i < 12; i++) begin
            cyc(tv[i].x, tv[i].y, tv[i].de, tv[i].hs, tv[i].vs, 1'b0);
            chk("tbl_rgb", {20'd0, last_rgb}, tv[i].rgb);
            chk("tbl_sync", {29'd0, h_sync_out, v_sync_out, de_out}, {29'd0, tv[i].hs, tv[i].vs, tv[i].de});
        end
        frame(4);

        // start with start and right held: single restart, player saturates at 608
        btn_start = 1; btn_right = 1;
        repeat (100) frame(4);
        btn_start = 0;
        pconst("right_clamp_in", 608, 448, 'h0F0);
        pconst("right_clamp_out", 607, 448, 0);
        pconst("right_clamp_edge", 639, 463, 'h0F0);
        btn_left = 1;
        repeat (5) frame(4);
        pconst("both_hold_in", 608, 448, 'h0F0);
        pconst("both_hold_out", 607, 448, 0);

        // spawn after 30 frames, retirement 120 frames later
        do_reset();
        start_pulse();
        btn_left = 1;
        repeat (30) frame(4);
        pconst("spawn_top_left", m_ox[0], 0, 'h840);
        pconst("spawn_bot_right", m_ox[0] + 15, 15, 'h840);
        pconst("spawn_below", m_ox[0], 16, 0);
        if (m_ox[0] > 0) pconst("spawn_left_out", m_ox[0] - 1, 0, 0);
        repeat (119) frame(4);
        if (m_state == 1) chk("score_before_retire", {16'd0, score}, 0);
        frame(4);
        if (m_state == 1) chk("score_after_retire", {16'd0, score}, 1);

        // steer under slot 0 and collide
        do_reset();
        start_pulse();
        repeat (30) frame(2);
        tgt = m_ox[0] - 8;
        tgt = tgt < 0 ? 0 : tgt > 608 ? 608 : tgt;
        for (int f = 0; f < 250 && m_state == 1; f++) begin
            btn_left = m_px - tgt >= 4;
            btn_right = tgt - m_px >= 4;
            frame(2);
        end
        btn_left = 0; btn_right = 0;
        chk("hit_game_over", {31'd0, game_over}, 1);
        px0 = m_px;
        pconst("over_player_red", px0, 448, 'hF00);
        btn_right = 1;
        repeat (3) frame(4);
        btn_right = 0;
        pconst("frozen_player", px0, 448, 'hF00);
        chk("frozen_score", {16'd0, score}, m_score);

        // restart from OVER with start held: clears once, then moves normally
        btn_start = 1; btn_right = 1;
        repeat (5) frame(4);
        btn_start = 0; btn_right = 0;
        chk("restart_score", {16'd0, score}, 0);
        chk("restart_over", {31'd0, game_over}, 0);
        pconst("restart_player_in", 324, 448, 'h0F0);
        pconst("restart_player_out", 323, 448, 0);

        // randomized play with a mid-frame reset
        for (int f = 0; f < 120; f++) begin
            btn_left = 1'($urandom); btn_right = 1'($urandom);
            btn_start = (m_state == 2) || ($urandom_range(0, 15) == 0);
            if (f == 60) begin
                px(320, 240); px(10, 10);
                cyc(320, 240, 1'b1, 1'b0, 1'b0, 1'b1);
                cyc(320, 240, 1'b1, 1'b0, 1'b1, 1'b0);
            end
            frame(6);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
